// File: rtl/indicador_ocupacion.sv
// rtl/indicador_ocupacion.sv - parking occupancy LED display with full blink, entry/exit flashes and rejection alarm
// All outputs are registered from next-state values, so inputs sampled at an edge show right after that edge.
module indicador_ocupacion #(
   parameter int CLK_FREQ        = 12000000,
   parameter int PARPADEO_CICLOS = CLK_FREQ*2,
   parameter int FLASH_CICLOS    = CLK_FREQ/4,
   parameter int CAPACIDAD       = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s,
   input  logic       r,
   input  logic [2:0] cuenta,
   output logic [3:0] led,
   output logic       lleno,
   output logic       vacio,
   output logic       evento_rechazo
);

   localparam int TW = (FLASH_CICLOS > 1) ? $clog2(FLASH_CICLOS) : 1;
   localparam int BW = (PARPADEO_CICLOS > 1) ? $clog2(PARPADEO_CICLOS) : 1;
   localparam logic [2:0]    CAP   = 3'(CAPACIDAD);
   localparam logic [TW-1:0] T_FIN = TW'(FLASH_CICLOS - 1);
   localparam logic [BW-1:0] B_FIN = BW'(PARPADEO_CICLOS - 1);

   typedef enum logic [1:0] {REPOSO, FLASH_ENTRADA, FLASH_SALIDA, RECHAZO} estado_t;

   estado_t       estado, estado_n;
   logic [TW-1:0] timer, timer_n;
   logic [1:0]    fase, fase_n;
   logic [BW-1:0] cnt_parp, cnt_parp_n;
   logic          parpadeo, parpadeo_n;
   logic          es_lleno, es_vacio;
   logic          ev_ent, ev_sal, ev_rech;
   logic [3:0]    led_n;

   always_comb begin
      es_lleno = (cuenta == CAP);
      es_vacio = (cuenta == 3'd0);
      ev_ent   = s & ~r & ~es_lleno;
      ev_sal   = r & ~s & ~es_vacio;
      ev_rech  = (s & ~r & es_lleno) | (r & ~s & es_vacio);

      estado_n = estado;
      timer_n  = timer;
      fase_n   = fase;
      // Latest event wins outside RECHAZO; inside RECHAZO every pulse is ignored.
      if (estado != RECHAZO && (ev_ent || ev_sal || ev_rech)) begin
         estado_n = ev_rech ? RECHAZO : (ev_ent ? FLASH_ENTRADA : FLASH_SALIDA);
         timer_n  = '0;
         fase_n   = 2'd0;
      end else begin
         case (estado)
            FLASH_ENTRADA, FLASH_SALIDA: begin
               if (timer >= T_FIN) begin
                  estado_n = REPOSO;
                  timer_n  = '0;
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            RECHAZO: begin
               if (timer >= T_FIN) begin
                  timer_n = '0;
                  if (fase == 2'd3) begin
                     estado_n = REPOSO;
                     fase_n   = 2'd0;
                  end else begin
                     fase_n = fase + 2'd1;
                  end
               end else begin
                  timer_n = timer + 1'b1;
               end
            end
            default: ;
         endcase
      end

      cnt_parp_n  = '0;
      parpadeo_n  = 1'b0;
      if (es_lleno) begin
         if (cnt_parp >= B_FIN) begin
            cnt_parp_n = '0;
            parpadeo_n = ~parpadeo;
         end else begin
            cnt_parp_n = cnt_parp + 1'b1;
            parpadeo_n = parpadeo;
         end
      end

      case (estado_n)
         FLASH_ENTRADA: led_n = {1'b1, cuenta};
         FLASH_SALIDA:  led_n = {parpadeo_n, 3'b000};
         RECHAZO:       led_n = fase_n[0] ? 4'b0000 : 4'b1111;
         default:       led_n = {parpadeo_n, cuenta};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado         <= REPOSO;
         timer          <= '0;
         fase           <= 2'd0;
         cnt_parp       <= '0;
         parpadeo       <= 1'b0;
         led            <= 4'b0000;
         lleno          <= 1'b0;
         vacio          <= 1'b0;
         evento_rechazo <= 1'b0;
      end else begin
         estado         <= estado_n;
         timer          <= timer_n;
         fase           <= fase_n;
         cnt_parp       <= cnt_parp_n;
         parpadeo       <= parpadeo_n;
         led            <= led_n;
         lleno          <= es_lleno;
         vacio          <= es_vacio;
         evento_rechazo <= (estado_n == RECHAZO) && (estado != RECHAZO);
      end
   end

endmodule
